// File: rtl/irq_controller_68k.sv
// Parametrised 68000-bus interrupt controller: synchronised active-low requests, per-source
// enable/mode/level, priority arbitration to the CPU IPL lines, and a word-addressed register window.
module irq_controller_68k #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               Clock,
  input  logic               Reset_L,
  input  logic               IrqSelect_H,
  input  logic               AS_L,
  input  logic               UDS_L,
  input  logic               LDS_L,
  input  logic               WE_L,
  input  logic [31:0]        Address,
  input  logic [15:0]        DataIn,
  output logic [15:0]        DataOut,
  output logic               Dtack_L,
  input  logic [NUM_IRQ-1:0] IRQ_L,
  output logic [2:0]         IPL_L
);

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  localparam logic [3:0] REG_PEND   = 4'd0;
  localparam logic [3:0] REG_ENABLE = 4'd1;
  localparam logic [3:0] REG_MODE   = 4'd2;
  localparam logic [3:0] REG_FORCE  = 4'd3;
  localparam logic [3:0] REG_ACTIVE = 4'd8;

  logic        as_prev_q;
  logic        dtack_q;
  logic [15:0] rd_data_q;
  logic [2:0]  ipl_q;
  logic        access_start;
  logic        wr_commit;
  logic [3:0]  word_idx;
  logic [15:0] lane_mask;
  logic [15:0] wr_bits;
  irq_vec_t    lane_vec;
  irq_vec_t    wr_vec;
  logic        wr_pend;
  logic        wr_enable;
  logic        wr_mode;
  logic        wr_force;
  logic        wr_level;

  irq_vec_t    sync_q [SYNC_STAGES];
  irq_vec_t    sync_prev_q;
  irq_vec_t    irq_sync;
  irq_vec_t    irq_asserted;
  irq_vec_t    irq_edge;

  irq_vec_t    pend_q;
  irq_vec_t    pend_next;
  irq_vec_t    enable_q;
  irq_vec_t    enable_next;
  irq_vec_t    mode_q;
  irq_vec_t    mode_next;
  logic [2:0]  level_q [NUM_IRQ];
  irq_vec_t    level_we;

  logic [2:0]  win_level;
  logic [3:0]  win_index;
  logic        win_valid;
  logic [15:0] active_word;
  logic [15:0] level_word [4];
  logic [15:0] read_data;

  // An access begins only on the falling edge of AS_L, so a long-held strobe commits once.
  assign access_start = IrqSelect_H && !AS_L && as_prev_q;
  assign wr_commit    = access_start && !WE_L;
  assign word_idx     = Address[4:1];
  assign lane_mask    = {{8{!UDS_L}}, {8{!LDS_L}}};
  assign wr_bits      = DataIn & lane_mask;
  assign lane_vec     = lane_mask[NUM_IRQ-1:0];
  assign wr_vec       = wr_bits[NUM_IRQ-1:0];

  assign wr_pend   = wr_commit && (word_idx == REG_PEND);
  assign wr_enable = wr_commit && (word_idx == REG_ENABLE);
  assign wr_mode   = wr_commit && (word_idx == REG_MODE);
  assign wr_force  = wr_commit && (word_idx == REG_FORCE);
  assign wr_level  = wr_commit && (word_idx[3:2] == 2'b01);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      sync_prev_q <= '1;
    end else begin
      sync_q[0] <= IRQ_L;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev_q <= irq_sync;
    end
  end

  assign irq_sync     = sync_q[SYNC_STAGES-1];
  assign irq_asserted = ~irq_sync;
  assign irq_edge     = sync_prev_q & ~irq_sync;

  always_comb begin
    enable_next = enable_q;
    mode_next   = mode_q;
    if (wr_enable) enable_next = (enable_q & ~lane_vec) | wr_vec;
    if (wr_mode)   mode_next   = (mode_q & ~lane_vec) | wr_vec;
  end

  // Edge-mode bits latch (a new edge beats a same-cycle clear); level-mode bits mirror the line.
  always_comb begin
    pend_next = pend_q;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (mode_q[n] && !mode_next[n]) begin
        pend_next[n] = 1'b0;
      end else if (mode_q[n]) begin
        if (irq_edge[n] || (wr_force && wr_vec[n])) pend_next[n] = 1'b1;
        else if (wr_pend && wr_vec[n])               pend_next[n] = 1'b0;
      end else begin
        pend_next[n] = irq_asserted[n];
      end
    end
  end

  always_comb begin
    level_we = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      level_we[n] = wr_level && (word_idx[1:0] == 2'(n / 4)) &&
                    (((n % 4) < 2) ? !LDS_L : !UDS_L);
    end
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      for (int n = 0; n < NUM_IRQ; n++) level_q[n] <= 3'd0;
    end else begin
      pend_q   <= pend_next;
      enable_q <= enable_next;
      mode_q   <= mode_next;
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (level_we[n]) level_q[n] <= DataIn[4*(n%4) +: 3];
      end
    end
  end

  // Strictly-greater comparison in ascending index order gives ties to the lowest source.
  always_comb begin
    win_level = 3'd0;
    win_index = 4'd0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (pend_q[n] && enable_q[n] && (level_q[n] > win_level)) begin
        win_level = level_q[n];
        win_index = 4'(n);
      end
    end
  end

  assign win_valid   = (win_level != 3'd0);
  assign active_word = {win_valid, 4'd0, win_level, 4'd0, win_index};

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) ipl_q <= 3'b111;
    else          ipl_q <= ~win_level;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) level_word[k] = 16'd0;
    for (int n = 0; n < NUM_IRQ; n++) level_word[n/4][4*(n%4) +: 3] = level_q[n];
  end

  always_comb begin
    read_data = 16'd0;
    case (word_idx)
      REG_PEND:                   read_data = 16'(pend_q);
      REG_ENABLE:                 read_data = 16'(enable_q);
      REG_MODE:                   read_data = 16'(mode_q);
      4'd4, 4'd5, 4'd6, 4'd7:     read_data = level_word[word_idx[1:0]];
      REG_ACTIVE:                 read_data = active_word;
      default:                    read_data = 16'd0;
    endcase
  end

  // Read data is captured once at access start and held until the strobe goes away.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      as_prev_q <= 1'b1;
      dtack_q   <= 1'b1;
      rd_data_q <= 16'd0;
    end else begin
      as_prev_q <= AS_L;
      if (access_start) begin
        dtack_q <= 1'b0;
        if (WE_L) rd_data_q <= read_data;
      end else if (AS_L) begin
        dtack_q <= 1'b1;
      end
    end
  end

  assign Dtack_L = dtack_q;
  assign IPL_L   = ipl_q;
  assign DataOut = (Reset_L && IrqSelect_H && !AS_L && WE_L) ? rd_data_q : 16'bz;

  logic unused_bits;
  assign unused_bits = ^{Address[31:5], Address[0], wr_bits, lane_mask};

endmodule

// File: tb/tb_irq_controller_68k.sv
// Scoreboard bench for irq_controller_68k: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_irq_controller_68k;

  localparam int NUM_IRQ     = 8;
  localparam int SYNC_STAGES = 2;

  logic               Clock = 1'b0;
  logic               Reset_L = 1'b0;
  logic               IrqSelect_H = 1'b0;
  logic               AS_L = 1'b1;
  logic               UDS_L = 1'b1;
  logic               LDS_L = 1'b1;
  logic               WE_L = 1'b1;
  logic [31:0]        Address = '0;
  logic [15:0]        DataIn = '0;
  wire  [15:0]        DataOut;
  logic               Dtack_L;
  logic [NUM_IRQ-1:0] IRQ_L = '1;
  logic [2:0]         IPL_L;

  int          checks = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];
  logic [15:0] got;
  logic [15:0] exp_val;

  irq_controller_68k #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
    .Clock(Clock), .Reset_L(Reset_L), .IrqSelect_H(IrqSelect_H), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L), .Address(Address), .DataIn(DataIn),
    .DataOut(DataOut), .Dtack_L(Dtack_L), .IRQ_L(IRQ_L), .IPL_L(IPL_L)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_access(input logic [3:0] idx, input logic we_n, input logic [15:0] wdata,
                            input logic uds_n, input logic lds_n, output logic [15:0] rdata);
    bit acked = 1'b0;
    @(negedge Clock);
    Address = {27'd0, idx, 1'b0};
    DataIn = wdata; WE_L = we_n; UDS_L = uds_n; LDS_L = lds_n;
    IrqSelect_H = 1'b1; AS_L = 1'b0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge Clock);
      if (Dtack_L === 1'b0) acked = 1'b1;
    end
    rdata = DataOut;
    if (!acked) begin
      checks++; fails++;
      $display("[TB] FAIL dtack_timeout: Dtack_L=%b required 0", Dtack_L);
    end
    AS_L = 1'b1; IrqSelect_H = 1'b0; UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [15:0] wdata);
    logic [15:0] dummy;
    bus_access(idx, 1'b0, wdata, 1'b0, 1'b0, dummy);
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [15:0] rdata);
    bus_access(idx, 1'b1, 16'h0000, 1'b0, 1'b0, rdata);
  endtask

  task automatic do_reset();
    IRQ_L = '1;
    Reset_L = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    IRQ_L = '0;
    Reset_L = 1'b0;
    repeat (3) @(negedge Clock);
    exp_q.push_back(16'h0007);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hzzzz);
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL reset_ipl: got %h expected %h", got, exp_val); end
    got = {15'd0, Dtack_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL reset_dtack: got %h expected %h", got, exp_val); end
    got = DataOut; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL reset_dataout: got %h expected %h", got, exp_val); end
    IRQ_L = '1;
    Reset_L = 1'b1;
    repeat (4) @(negedge Clock);
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back(16'h0000);
      bus_read(4'(w), got);
      exp_val = exp_q.pop_front(); checks++;
      if (got !== exp_val) begin fails++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", w, got, exp_val); end
    end
  endtask

  task automatic test_edge_latency();
    do_reset();
    bus_write(4'd2, 16'h0001);
    bus_write(4'd1, 16'h0001);
    bus_write(4'd4, 16'h0005);
    @(negedge Clock);
    IRQ_L[0] = 1'b0;
    exp_q.push_back(16'h0007); exp_q.push_back(16'h0007);
    exp_q.push_back(16'h0007); exp_q.push_back(16'h0002);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      if (c == 1) IRQ_L[0] = 1'b1;
      got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
      if (got !== exp_val) begin fails++; $display("[TB] FAIL edge_latency_c%0d: got %h expected %h", c, got, exp_val); end
    end
    exp_q.push_back(16'h0001);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL edge_pend_latched: got %h expected %h", got, exp_val); end
    bus_write(4'd0, 16'h0001);
    @(negedge Clock);
    exp_q.push_back(16'h0007);
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL edge_w1c_ipl: got %h expected %h", got, exp_val); end
    exp_q.push_back(16'h0000);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL edge_w1c_pend: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_level_priority();
    do_reset();
    bus_write(4'd4, 16'h2000);
    bus_write(4'd5, 16'h0060);
    bus_write(4'd1, 16'h0028);
    IRQ_L[3] = 1'b0; IRQ_L[5] = 1'b0;
    repeat (5) @(negedge Clock);
    exp_q.push_back(16'h8605); exp_q.push_back(16'h0001);
    bus_read(4'd8, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL level_active_hi: got %h expected %h", got, exp_val); end
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL level_ipl_hi: got %h expected %h", got, exp_val); end
    IRQ_L[5] = 1'b1;
    repeat (5) @(negedge Clock);
    exp_q.push_back(16'h8203); exp_q.push_back(16'h0005);
    bus_read(4'd8, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL level_active_lo: got %h expected %h", got, exp_val); end
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL level_ipl_lo: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_tie();
    do_reset();
    bus_write(4'd4, 16'h0030);
    bus_write(4'd5, 16'h0003);
    bus_write(4'd1, 16'h0012);
    IRQ_L[1] = 1'b0; IRQ_L[4] = 1'b0;
    repeat (5) @(negedge Clock);
    exp_q.push_back(16'h8301); exp_q.push_back(16'h0004);
    bus_read(4'd8, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL tie_active: got %h expected %h", got, exp_val); end
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL tie_ipl: got %h expected %h", got, exp_val); end
    bus_write(4'd1, 16'h0010);
    @(negedge Clock);
    exp_q.push_back(16'h8304);
    bus_read(4'd8, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL tie_after_disable: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_force();
    do_reset();
    bus_write(4'd2, 16'h0080);
    bus_write(4'd5, 16'h7000);
    bus_write(4'd1, 16'h00C0);
    bus_write(4'd3, 16'h0080);
    @(negedge Clock);
    exp_q.push_back(16'h0000);
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL force_ipl: got %h expected %h", got, exp_val); end
    bus_write(4'd3, 16'h0040);
    exp_q.push_back(16'h0080); exp_q.push_back(16'h0000);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL force_level_src: got %h expected %h", got, exp_val); end
    bus_read(4'd3, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL force_readback: got %h expected %h", got, exp_val); end
    bus_write(4'd2, 16'h0000);
    exp_q.push_back(16'h0000);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL mode_clear_pend: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    bus_access(4'd1, 1'b0, 16'hFFFF, 1'b0, 1'b1, got);
    exp_q.push_back(16'h0000);
    bus_read(4'd1, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL lane_upper_enable: got %h expected %h", got, exp_val); end
    bus_access(4'd1, 1'b0, 16'hFFFF, 1'b1, 1'b0, got);
    exp_q.push_back(16'h00FF);
    bus_read(4'd1, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL lane_lower_enable: got %h expected %h", got, exp_val); end
    bus_access(4'd4, 1'b0, 16'hFFFF, 1'b0, 1'b1, got);
    exp_q.push_back(16'h7700);
    bus_read(4'd4, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL lane_upper_level: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_write(4'd2, 16'h0003);
    bus_write(4'd3, 16'h0003);
    exp_q.push_back(16'h0003);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL held_setup_pend: got %h expected %h", got, exp_val); end
    @(negedge Clock);
    Address = 32'd0; DataIn = 16'h0003; WE_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
    IrqSelect_H = 1'b1; AS_L = 1'b0;
    @(negedge Clock);
    IRQ_L[0] = 1'b0;
    @(negedge Clock);
    IRQ_L[0] = 1'b1;
    repeat (3) @(negedge Clock);
    AS_L = 1'b1; IrqSelect_H = 1'b0; WE_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    repeat (2) @(negedge Clock);
    exp_q.push_back(16'h0001);
    bus_read(4'd0, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL held_w1c_single: got %h expected %h", got, exp_val); end
  endtask

  task automatic test_reset_mid_access();
    bus_write(4'd1, 16'h0001);
    bus_write(4'd4, 16'h0005);
    @(negedge Clock);
    exp_q.push_back(16'h0002);
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL midreset_pre_ipl: got %h expected %h", got, exp_val); end
    @(negedge Clock);
    Address = {27'd0, 4'd1, 1'b0}; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    IrqSelect_H = 1'b1; AS_L = 1'b0;
    @(negedge Clock);
    Reset_L = 1'b0;
    #1;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0007); exp_q.push_back(16'hzzzz);
    got = {15'd0, Dtack_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL midreset_dtack: got %h expected %h", got, exp_val); end
    got = {13'd0, IPL_L}; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL midreset_ipl: got %h expected %h", got, exp_val); end
    got = DataOut; exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL midreset_dataout: got %h expected %h", got, exp_val); end
    AS_L = 1'b1; IrqSelect_H = 1'b0; UDS_L = 1'b1; LDS_L = 1'b1;
    @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);
    exp_q.push_back(16'h0000);
    bus_read(4'd1, got);
    exp_val = exp_q.pop_front(); checks++;
    if (got !== exp_val) begin fails++; $display("[TB] FAIL midreset_enable: got %h expected %h", got, exp_val); end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_level_priority();
    test_tie();
    test_force();
    test_byte_lanes();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
